uart_tx_fifo: RTL and testbench

- Parametrised, synthesizable UART transmitter with an integrated transmit FIFO and an internal baud-tick divider.
- Successor to the fixed 8N1, externally clocked serial stimulus used around the CPU.
- Adds configurable data width, parity, stop bits and buffering depth.
- Serves both as the CPU's UART TX path and as a reusable serial stimulus source for CPU-level benches.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_fifo_if.sv | 33 +++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART blocks.
// Parity modes, TX FSM encoding and small sizing helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int CLKS_PER_BIT_DEF = 5208;
  localparam int MAX_DATA_BITS    = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic parity_bit(
    input logic [MAX_DATA_BITS-1:0] w,
    input int                       mode
  );
    return (mode == PAR_ODD) ? ~^w : ^w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write port and status/serial outputs of the
// buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  import uart_pkg::*;

  localparam int LW = lvl_w(FIFO_DEPTH);

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [LW-1:0]        level;
  logic                 drop;
  logic                 tx;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, drop,
    input  tx, busy, frame_done
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, drop,
    output tx, busy, frame_done
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered level/full/empty.
// A push while full is taken when a pop happens in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             push_ok_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             pop_ok;

  assign pop_ok    = pop_i && !empty_q;
  assign push_ok_o = push_i && (!full_q || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_o) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)    rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push_ok_o) - LW'(pop_ok);
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with configurable frame
// format and internal per-bit divider.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam int LW = lvl_w(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 drop_q, drop_d;

  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 pop;
  logic                 push_ok;
  logic                 full;
  logic                 empty;
  logic [LW-1:0]        level;
  logic                 tick;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (bus.wr_en),
    .wdata_i   (bus.wr_data),
    .pop_i     (pop),
    .rdata_o   (head),
    .push_ok_o (push_ok),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level)
  );

  assign tick     = (div_q == DIV_LAST);
  assign head_par = parity_bit(MAX_DATA_BITS'(head), PARITY);
  assign drop_d   = bus.wr_en && !push_ok;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != ST_IDLE) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        div_d = '0;
        bit_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next frame when data waits.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = head_par;
              tx_d    = 1'b0;
              state_d = ST_START;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = (state_q == ST_STOP) && tick &&
                          (bit_q == STOP_LAST);
  assign bus.drop       = drop_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo
// against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int NL  = 8192;
  localparam int FL  = 40;
  localparam int RL  = 800;

  typedef bit bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wen = '0;
  logic [8:0] wd  = '0;

  int checks = 0;
  int errors = 0;
  int ncnt   = 0;

  logic       lg_tx   [4][NL];
  logic       lg_fd   [4][NL];
  logic       lg_busy [4][NL];
  logic [2:0] lg_lvl  [NL];
  logic       lg_full [NL];
  logic       lg_empty[NL];
  logic       lg_drop [NL];

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) i0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) i1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) i2 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) i3 ();

  assign i0.wr_en   = wen[0];
  assign i1.wr_en   = wen[1];
  assign i2.wr_en   = wen[2];
  assign i3.wr_en   = wen[3];
  assign i0.wr_data = wd[7:0];
  assign i1.wr_data = wd[7:0];
  assign i2.wr_data = wd[7:0];
  assign i3.wr_data = wd[6:0];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4))
    d0 (.clk(clk), .reset(rst), .bus(i0));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4))
    d1 (.clk(clk), .reset(rst), .bus(i1));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(1), .FIFO_DEPTH(4))
    d2 (.clk(clk), .reset(rst), .bus(i2));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0),
    .STOP_BITS(2), .FIFO_DEPTH(4))
    d3 (.clk(clk), .reset(rst), .bus(i3));

  // Index n holds the outputs seen after the n-th rising edge.
  always @(negedge clk) begin
    if (ncnt < NL) begin
      lg_tx[0][ncnt]   = i0.tx;
      lg_tx[1][ncnt]   = i1.tx;
      lg_tx[2][ncnt]   = i2.tx;
      lg_tx[3][ncnt]   = i3.tx;
      lg_fd[0][ncnt]   = i0.frame_done;
      lg_fd[1][ncnt]   = i1.frame_done;
      lg_fd[2][ncnt]   = i2.frame_done;
      lg_fd[3][ncnt]   = i3.frame_done;
      lg_busy[0][ncnt] = i0.busy;
      lg_busy[1][ncnt] = i1.busy;
      lg_busy[2][ncnt] = i2.busy;
      lg_busy[3][ncnt] = i3.busy;
      lg_lvl[ncnt]     = i0.level;
      lg_full[ncnt]    = i0.full;
      lg_empty[ncnt]   = i0.empty;
      lg_drop[ncnt]    = i0.drop;
    end
    ncnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int idx);
    while (ncnt <= idx) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t wave(input int w, input int db,
                               input int par, input int sb);
    bq_t b;
    bq_t q;
    int  ones;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      b.push_back(w[i]);
      ones += w[i];
    end
    if (par == 1) b.push_back(ones % 2 == 0);
    if (par == 2) b.push_back(ones % 2 == 1);
    for (int i = 0; i < sb; i++) b.push_back(1'b1);
    foreach (b[i]) begin
      for (int j = 0; j < CPB; j++) q.push_back(b[i]);
    end
    return q;
  endfunction

  task automatic chk_wave(input int k, input int s, input bq_t q,
                          input string tag);
    int bad;
    bad = 0;
    wait_idx(s + q.size() - 1);
    foreach (q[i]) begin
      if (lg_tx[k][s+i] !== q[i]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_fd(input int k, input int s, input int n,
                        input int len, input string tag);
    int bad;
    bad = 0;
    wait_idx(s + n*len - 1);
    for (int i = 0; i < n*len; i++) begin
      if (lg_fd[k][s+i] !== ((i + 1) % len == 0)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic run_frame(input int k, input int w, input int db,
                           input int par, input int sb,
                           input string tag, output int s);
    bq_t q;
    bq_t idle;
    int  n0;
    q  = wave(w, db, par, sb);
    n0 = ncnt;
    s  = n0 + 2;
    wd = 9'(w);
    wen[k] = 1'b1;
    step();
    wen[k] = 1'b0;
    chk_wave(k, s, q, {tag, "_wave"});
    chk_fd(k, s, 1, q.size(), {tag, "_fd"});
    for (int i = 0; i < 8; i++) idle.push_back(1'b1);
    chk_wave(k, s + q.size(), idle, {tag, "_idle"});
    chk({tag, "_busy"}, lg_busy[k][s], 1);
    chk({tag, "_unbusy"}, lg_busy[k][s + q.size()], 0);
    if (k == 0) chk({tag, "_lvl1"}, lg_lvl[n0+1], 1);
  endtask

  int   s, n0, m, mx, r0, bad, base;
  bq_t  q, ones_q;
  int   rw [RL];
  int   rdv[RL];
  int   words[4];
  int   fwords[6];

  initial begin
    step();
    step();
    chk("rst_tx", i0.tx, 1);
    chk("rst_busy", i0.busy, 0);
    chk("rst_full", i0.full, 0);
    chk("rst_empty", i0.empty, 1);
    chk("rst_level", i0.level, 0);
    chk("rst_drop", i0.drop, 0);
    chk("rst_fd", i0.frame_done, 0);
    rst = 1'b0;
    step();

    run_frame(0, 'hA5, 8, 0, 1, "a5", s);
    run_frame(1, 'h07, 8, 2, 1, "even", s);
    chk("even_bit", lg_tx[1][s + 9*CPB], 1);
    run_frame(2, 'h07, 8, 1, 1, "odd", s);
    chk("odd_bit", lg_tx[2][s + 9*CPB], 0);
    run_frame(3, 'h55, 7, 0, 2, "d7s2", s);

    // Back-to-back frames from four consecutive writes.
    words = '{'h11, 'h22, 'h33, 'h44};
    n0 = ncnt;
    s  = n0 + 2;
    q  = {};
    foreach (words[i]) begin
      wd = 9'(words[i]);
      wen[0] = 1'b1;
      step();
      q = {q, wave(words[i], 8, 0, 1)};
    end
    wen[0] = 1'b0;
    chk_wave(0, s, q, "b2b_wave");
    chk_fd(0, s, 4, FL, "b2b_fd");
    mx = 0;
    for (int i = n0 + 1; i <= n0 + 6; i++) begin
      if (int'(lg_lvl[i]) > mx) mx = int'(lg_lvl[i]);
    end
    chk("b2b_peak", mx, 3);
    chk("b2b_empty_pre", lg_empty[s + 3*FL - 1], 0);
    chk("b2b_empty", lg_empty[s + 3*FL], 1);

    // Overflow while the FSM is mid-frame, then push on a pop.
    fwords = '{'h5A, 'h01, 'h02, 'h03, 'h04, 'hC3};
    n0 = ncnt;
    s  = n0 + 2;
    wd = 9'(fwords[0]);
    wen[0] = 1'b1;
    step();
    wen[0] = 1'b0;
    step();
    step();
    m = ncnt;
    for (int i = 1; i <= 5; i++) begin
      wd = (i == 5) ? 9'h0EE : 9'(fwords[i]);
      wen[0] = 1'b1;
      step();
    end
    wen[0] = 1'b0;
    wait_idx(m + 6);
    chk("ovf_full", lg_full[m+4], 1);
    chk("ovf_lvl4", lg_lvl[m+4], 4);
    chk("ovf_nodrop", lg_drop[m+4], 0);
    chk("ovf_drop", lg_drop[m+5], 1);
    chk("ovf_drop_end", lg_drop[m+6], 0);
    chk("ovf_lvl_hold", lg_lvl[m+6], 4);
    while (ncnt < s + FL - 1) step();
    wd = 9'(fwords[5]);
    wen[0] = 1'b1;
    step();
    wen[0] = 1'b0;
    wait_idx(s + FL);
    chk("pp_nodrop", lg_drop[s+FL], 0);
    chk("pp_lvl", lg_lvl[s+FL], 4);
    chk("pp_full", lg_full[s+FL], 1);
    q = {};
    foreach (fwords[i]) q = {q, wave(fwords[i], 8, 0, 1)};
    chk_wave(0, s, q, "ovf_wave");
    chk_fd(0, s, 6, FL, "ovf_fd");

    // Reset in the middle of the data bits.
    n0 = ncnt;
    s  = n0 + 2;
    wd = 9'h0F0;
    wen[0] = 1'b1;
    step();
    wd = 9'h00F;
    step();
    wen[0] = 1'b0;
    while (ncnt < s + 12) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_tx", i0.tx, 1);
    chk("mrst_busy", i0.busy, 0);
    chk("mrst_level", i0.level, 0);
    chk("mrst_empty", i0.empty, 1);
    r0 = ncnt;
    ones_q = {};
    for (int i = 0; i < 60; i++) ones_q.push_back(1'b1);
    chk_wave(0, r0, ones_q, "mrst_quiet");
    bad = 0;
    for (int i = 0; i < 60; i++) bad += int'(lg_fd[0][r0+i]);
    chk("mrst_nofd", bad, 0);
    run_frame(0, 'h3C, 8, 0, 1, "post_rst", s);

    // Random writes against a transaction-level model.
    base = ncnt;
    for (int i = 0; i < RL; i++) begin
      if (i < RL/2) wen[0] = ($urandom_range(0, 5) == 0);
      else          wen[0] = ($urandom_range(0, 39) == 0);
      wd = 9'($urandom_range(0, 255));
      rw[i]  = int'(wen[0]);
      rdv[i] = int'(wd);
      step();
    end
    wen[0] = 1'b0;
    wait_idx(base + RL + 250);
    begin
      int  mq[$];
      bq_t fq;
      int  free_at, fs, ex_tx, i, btx, blv, bdr, bfd;
      bit  p, wr, acc;
      free_at = base + 1;
      fs  = -100000;
      btx = 0;
      blv = 0;
      bdr = 0;
      bfd = 0;
      for (int e = base + 1; e <= base + RL + 250; e++) begin
        i   = e - base - 1;
        wr  = (i < RL) ? (rw[i] != 0) : 1'b0;
        p   = (mq.size() > 0) && (e >= free_at);
        acc = wr && ((mq.size() < 4) || p);
        if (p) begin
          fs = e;
          fq = wave(mq.pop_front(), 8, 0, 1);
          free_at = e + FL;
        end
        if (acc) mq.push_back(rdv[i]);
        ex_tx = (e >= fs && e < fs + FL) ? int'(fq[e-fs]) : 1;
        if (lg_tx[0][e] !== ex_tx[0]) btx++;
        if (int'(lg_lvl[e]) != mq.size()) blv++;
        if (lg_drop[e] !== (wr && !acc)) bdr++;
        if (lg_fd[0][e] !== (e == fs + FL - 1)) bfd++;
      end
      chk("rnd_tx", btx, 0);
      chk("rnd_level", blv, 0);
      chk("rnd_drop", bdr, 0);
      chk("rnd_fd", bfd, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
